// File: rtl/cv32e40x_mpu.sv
// Memory protection unit between a core transaction requester and the OBI bus.
// PMA-failing requests are consumed locally and answered with an in-order error response.
module cv32e40x_mpu #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        core_trans_valid_i,
  output logic        core_trans_ready_o,
  input  logic [31:0] core_trans_addr_i,
  input  logic        core_trans_we_i,
  input  logic [31:0] core_trans_wdata_i,

  output logic        core_resp_valid_o,
  output logic [31:0] core_resp_rdata_o,
  output logic        core_resp_mpu_err_o,

  output logic [31:0] pma_trans_addr_o,
  input  logic        pma_err_i,
  input  logic        pma_bufferable_i,
  input  logic        pma_cacheable_i,

  output logic        bus_trans_valid_o,
  input  logic        bus_trans_ready_i,
  output logic [31:0] bus_trans_addr_o,
  output logic        bus_trans_we_o,
  output logic [31:0] bus_trans_wdata_o,
  output logic        bus_trans_bufferable_o,
  output logic        bus_trans_cacheable_o,

  input  logic        bus_resp_valid_i,
  input  logic [31:0] bus_resp_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DRAIN,
    ERR_RESP
  } state_e;

  localparam logic [1:0] MaxCnt = 2'(MAX_OUTSTANDING);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       cnt_ok;
  logic       bus_accept;
  logic       resp_dec;

  assign cnt_ok = (cnt_q < MaxCnt);

  assign pma_trans_addr_o       = core_trans_addr_i;
  assign bus_trans_addr_o       = core_trans_addr_i;
  assign bus_trans_we_o         = core_trans_we_i;
  assign bus_trans_wdata_o      = core_trans_wdata_i;
  assign bus_trans_bufferable_o = pma_bufferable_i;
  assign bus_trans_cacheable_o  = pma_cacheable_i;

  always_comb begin
    state_d             = state_q;
    core_trans_ready_o  = 1'b0;
    bus_trans_valid_o   = 1'b0;
    core_resp_valid_o   = bus_resp_valid_i;
    core_resp_rdata_o   = bus_resp_rdata_i;
    core_resp_mpu_err_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_trans_valid_i && pma_err_i) begin
          // Blocked request is consumed here; the error waits until the bus has drained.
          core_trans_ready_o = 1'b1;
          if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && bus_resp_valid_i)) begin
            state_d = ERR_RESP;
          end else begin
            state_d = WAIT_DRAIN;
          end
        end else begin
          bus_trans_valid_o  = core_trans_valid_i & cnt_ok;
          core_trans_ready_o = bus_trans_ready_i & cnt_ok;
        end
      end

      WAIT_DRAIN: begin
        if ((cnt_q == 2'd1) && bus_resp_valid_i) begin
          state_d = ERR_RESP;
        end
      end

      ERR_RESP: begin
        core_resp_valid_o   = 1'b1;
        core_resp_rdata_o   = 32'h0;
        core_resp_mpu_err_o = 1'b1;
        state_d             = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_accept = bus_trans_valid_o & bus_trans_ready_i;
  // A stray response with nothing outstanding must not wrap the counter.
  assign resp_dec   = bus_resp_valid_i & (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (bus_accept && !resp_dec) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!bus_accept && resp_dec) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  a_resp_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) bus_resp_valid_i |-> (cnt_q != 2'd0));

  a_no_resp_in_err: assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == ERR_RESP) |-> !bus_resp_valid_i);

endmodule

// File: tb/tb_cv32e40x_mpu.sv
// Bench for cv32e40x_mpu: directed stimulus, an outstanding-count/owed-error model
// checked every cycle, and hand-computed expectations at key points.
module tb_cv32e40x_mpu;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        core_trans_valid_i = 1'b0;
  logic        core_trans_ready_o;
  logic [31:0] core_trans_addr_i = '0;
  logic        core_trans_we_i = 1'b0;
  logic [31:0] core_trans_wdata_i = '0;
  logic        core_resp_valid_o;
  logic [31:0] core_resp_rdata_o;
  logic        core_resp_mpu_err_o;
  logic [31:0] pma_trans_addr_o;
  logic        pma_err_i = 1'b0;
  logic        pma_bufferable_i = 1'b0;
  logic        pma_cacheable_i = 1'b0;
  logic        bus_trans_valid_o;
  logic        bus_trans_ready_i = 1'b0;
  logic [31:0] bus_trans_addr_o;
  logic        bus_trans_we_o;
  logic [31:0] bus_trans_wdata_o;
  logic        bus_trans_bufferable_o;
  logic        bus_trans_cacheable_o;
  logic        bus_resp_valid_i = 1'b0;
  logic [31:0] bus_resp_rdata_i = '0;

  int n_checks = 0;
  int n_err    = 0;

  // Model: bus transactions in flight, an error response owed but waiting, an error response due now.
  int m_out  = 0;
  bit m_pend = 1'b0;
  bit m_due  = 1'b0;

  always #5 clk = ~clk;

  cv32e40x_mpu #(.MAX_OUTSTANDING(MAX)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .core_trans_valid_i     (core_trans_valid_i),
    .core_trans_ready_o     (core_trans_ready_o),
    .core_trans_addr_i      (core_trans_addr_i),
    .core_trans_we_i        (core_trans_we_i),
    .core_trans_wdata_i     (core_trans_wdata_i),
    .core_resp_valid_o      (core_resp_valid_o),
    .core_resp_rdata_o      (core_resp_rdata_o),
    .core_resp_mpu_err_o    (core_resp_mpu_err_o),
    .pma_trans_addr_o       (pma_trans_addr_o),
    .pma_err_i              (pma_err_i),
    .pma_bufferable_i       (pma_bufferable_i),
    .pma_cacheable_i        (pma_cacheable_i),
    .bus_trans_valid_o      (bus_trans_valid_o),
    .bus_trans_ready_i      (bus_trans_ready_i),
    .bus_trans_addr_o       (bus_trans_addr_o),
    .bus_trans_we_o         (bus_trans_we_o),
    .bus_trans_wdata_o      (bus_trans_wdata_o),
    .bus_trans_bufferable_o (bus_trans_bufferable_o),
    .bus_trans_cacheable_o  (bus_trans_cacheable_o),
    .bus_resp_valid_i       (bus_resp_valid_i),
    .bus_resp_rdata_i       (bus_resp_rdata_i)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit blocking_now();
    return m_due || m_pend;
  endfunction

  function automatic logic exp_resp_valid();
    return m_due ? 1'b1 : bus_resp_valid_i;
  endfunction

  function automatic logic exp_mpu_err();
    return m_due;
  endfunction

  function automatic logic [31:0] exp_rdata();
    return m_due ? 32'h0 : bus_resp_rdata_i;
  endfunction

  function automatic logic exp_bus_valid();
    if (blocking_now() || !core_trans_valid_i || pma_err_i) return 1'b0;
    return (m_out < MAX);
  endfunction

  function automatic logic exp_ready();
    if (blocking_now()) return 1'b0;
    if (pma_err_i) return 1'b1;
    return bus_trans_ready_i && (m_out < MAX);
  endfunction

  function automatic bit ready_meaningful();
    return core_trans_valid_i || blocking_now();
  endfunction

  function automatic int next_out();
    int o;
    o = m_out;
    if (exp_bus_valid() && bus_trans_ready_i) o++;
    if (bus_resp_valid_i && m_out > 0) o--;
    return o;
  endfunction

  function automatic bit owed_next();
    return m_pend || (!m_due && core_trans_valid_i && pma_err_i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out  <= 0;
      m_pend <= 1'b0;
      m_due  <= 1'b0;
    end else begin
      m_out  <= next_out();
      m_due  <= owed_next() && (next_out() == 0);
      m_pend <= owed_next() && (next_out() != 0);
    end
  end

  always @(negedge clk) begin
    chk1("resp_valid", core_resp_valid_o, exp_resp_valid());
    chk1("resp_mpu_err", core_resp_mpu_err_o, exp_mpu_err());
    chk32("resp_rdata", core_resp_rdata_o, exp_rdata());
    if (ready_meaningful()) chk1("trans_ready", core_trans_ready_o, exp_ready());
    chk1("bus_valid", bus_trans_valid_o, exp_bus_valid());
    chk32("bus_addr", bus_trans_addr_o, core_trans_addr_i);
    chk32("pma_addr", pma_trans_addr_o, core_trans_addr_i);
    chk1("bus_we", bus_trans_we_o, core_trans_we_i);
    chk32("bus_wdata", bus_trans_wdata_o, core_trans_wdata_i);
    chk1("bus_bufferable", bus_trans_bufferable_o, pma_bufferable_i);
    chk1("bus_cacheable", bus_trans_cacheable_o, pma_cacheable_i);
  end

  task automatic set(input logic v, input logic [31:0] a, input logic perr,
                     input logic rv, input logic [31:0] rd);
    core_trans_valid_i = v;
    core_trans_addr_i  = a;
    core_trans_we_i    = a[2];
    core_trans_wdata_i = {a[15:0], ~a[15:0]};
    pma_err_i          = perr;
    pma_bufferable_i   = a[8];
    pma_cacheable_i    = a[12];
    bus_trans_ready_i  = 1'b1;
    bus_resp_valid_i   = rv;
    bus_resp_rdata_i   = rd;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every input low
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_resp_valid", core_resp_valid_o, 1'b0);
    chk1("rst_mpu_err", core_resp_mpu_err_o, 1'b0);
    chk32("rst_rdata", core_resp_rdata_o, 32'h0);
    chk1("rst_ready", core_trans_ready_o, 1'b0);
    chk1("rst_bus_valid", bus_trans_valid_o, 1'b0);
    nxt(); nxt();
    rst_n = 1'b1;

    // Clean read, response one cycle later
    set(1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0); #3;
    chk1("t1_bus_valid", bus_trans_valid_o, 1'b1);
    chk1("t1_ready", core_trans_ready_o, 1'b1);
    chk32("t1_bus_addr", bus_trans_addr_o, 32'h0000_1000);
    chk1("t1_cacheable", bus_trans_cacheable_o, 1'b1);
    nxt();
    set(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF); #3;
    chk1("t1_resp_valid", core_resp_valid_o, 1'b1);
    chk32("t1_rdata", core_resp_rdata_o, 32'hDEAD_BEEF);
    chk1("t1_mpu_err", core_resp_mpu_err_o, 1'b0);
    nxt();

    // Blocked request with nothing outstanding
    set(1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0); #3;
    chk1("t2_ready", core_trans_ready_o, 1'b1);
    chk1("t2_bus_valid", bus_trans_valid_o, 1'b0);
    nxt();
    set(1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'h0); #3;
    chk1("t2_err_valid", core_resp_valid_o, 1'b1);
    chk1("t2_err_flag", core_resp_mpu_err_o, 1'b1);
    chk32("t2_err_rdata", core_resp_rdata_o, 32'h0);
    chk1("t2_err_ready", core_trans_ready_o, 1'b0);
    chk1("t2_err_bus_valid", bus_trans_valid_o, 1'b0);
    nxt();
    set(1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'h0); #3;
    chk1("t2_idle_ready", core_trans_ready_o, 1'b1);
    chk1("t2_idle_resp", core_resp_valid_o, 1'b0);
    nxt();
    set(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111); #3;
    chk1("t2_fwd_err", core_resp_mpu_err_o, 1'b0);
    nxt();

    // Two clean outstanding, then blocked: drain before error
    set(1'b1, 32'h0000_4000, 1'b0, 1'b0, 32'h0); nxt();
    set(1'b1, 32'h0000_4004, 1'b0, 1'b0, 32'h0); #3;
    chk1("t3_second_ready", core_trans_ready_o, 1'b1);
    nxt();
    set(1'b1, 32'h0000_4008, 1'b1, 1'b0, 32'h0); #3;
    chk1("t3_block_ready", core_trans_ready_o, 1'b1);
    nxt();
    set(1'b1, 32'h0000_400C, 1'b0, 1'b0, 32'h0); #3;
    chk1("t3_drain_ready", core_trans_ready_o, 1'b0);
    chk1("t3_drain_bus_valid", bus_trans_valid_o, 1'b0);
    chk1("t3_drain_resp", core_resp_valid_o, 1'b0);
    nxt();
    set(1'b1, 32'h0000_400C, 1'b0, 1'b1, 32'h0000_00A1); #3;
    chk32("t3_fwd1", core_resp_rdata_o, 32'h0000_00A1);
    chk1("t3_fwd1_err", core_resp_mpu_err_o, 1'b0);
    nxt();
    set(1'b1, 32'h0000_400C, 1'b0, 1'b1, 32'h0000_00A2); #3;
    chk32("t3_fwd2", core_resp_rdata_o, 32'h0000_00A2);
    chk1("t3_fwd2_err", core_resp_mpu_err_o, 1'b0);
    nxt();
    set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #3;
    chk1("t3_err_valid", core_resp_valid_o, 1'b1);
    chk1("t3_err_flag", core_resp_mpu_err_o, 1'b1);
    nxt();
    set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #3;
    chk1("t3_after_err", core_resp_valid_o, 1'b0);
    nxt();

    // Outstanding limit and simultaneous accept/response
    set(1'b1, 32'h0000_5000, 1'b0, 1'b0, 32'h0); nxt();
    set(1'b1, 32'h0000_5004, 1'b0, 1'b0, 32'h0); nxt();
    set(1'b1, 32'h0000_5008, 1'b0, 1'b0, 32'h0); #3;
    chk1("t4_full_ready", core_trans_ready_o, 1'b0);
    chk1("t4_full_bus_valid", bus_trans_valid_o, 1'b0);
    nxt();
    set(1'b1, 32'h0000_5008, 1'b0, 1'b1, 32'h0000_00B1); #3;
    chk1("t4_full_ready_resp", core_trans_ready_o, 1'b0);
    nxt();
    set(1'b1, 32'h0000_5008, 1'b0, 1'b0, 32'h0); #3;
    chk1("t4_freed_ready", core_trans_ready_o, 1'b1);
    nxt();
    set(1'b1, 32'h0000_500C, 1'b0, 1'b1, 32'h0000_00B2); #3;
    chk1("t4_refull_ready", core_trans_ready_o, 1'b0);
    nxt();
    set(1'b1, 32'h0000_500C, 1'b0, 1'b1, 32'h0000_00B3); #3;
    chk1("t4_simul_ready", core_trans_ready_o, 1'b1);
    chk1("t4_simul_resp", core_resp_valid_o, 1'b1);
    nxt();
    set(1'b1, 32'h0000_5010, 1'b0, 1'b0, 32'h0); #3;
    chk1("t4_after_simul_ready", core_trans_ready_o, 1'b1);
    nxt();
    set(1'b1, 32'h0000_5014, 1'b0, 1'b0, 32'h0); #3;
    chk1("t4_full_again", core_trans_ready_o, 1'b0);
    nxt();
    set(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00B4); nxt();
    set(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00B5); nxt();

    // Blocked with one outstanding whose response lands the same cycle
    set(1'b1, 32'h0000_6000, 1'b0, 1'b0, 32'h0); nxt();
    set(1'b1, 32'h0000_6004, 1'b1, 1'b1, 32'h0000_00C1); #3;
    chk1("t5_ready", core_trans_ready_o, 1'b1);
    chk32("t5_fwd", core_resp_rdata_o, 32'h0000_00C1);
    nxt();
    set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #3;
    chk1("t5_err_direct", core_resp_mpu_err_o, 1'b1);
    nxt();

    // Blocked with two outstanding and a same-cycle response: must still wait
    set(1'b1, 32'h0000_6100, 1'b0, 1'b0, 32'h0); nxt();
    set(1'b1, 32'h0000_6104, 1'b0, 1'b0, 32'h0); nxt();
    set(1'b1, 32'h0000_6108, 1'b1, 1'b1, 32'h0000_00C2); nxt();
    set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #3;
    chk1("t5b_no_early_err", core_resp_valid_o, 1'b0);
    nxt();
    set(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00C3); #3;
    chk1("t5b_fwd_err", core_resp_mpu_err_o, 1'b0);
    nxt();
    set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #3;
    chk1("t5b_err", core_resp_mpu_err_o, 1'b1);
    nxt();

    // Reset while draining
    set(1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'h0); nxt();
    set(1'b1, 32'h0000_7004, 1'b1, 1'b0, 32'h0); nxt();
    set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_rst_resp", core_resp_valid_o, 1'b0);
    chk1("t6_rst_bus_valid", bus_trans_valid_o, 1'b0);
    nxt();
    rst_n = 1'b1;
    set(1'b1, 32'h0000_7100, 1'b0, 1'b0, 32'h0); #3;
    chk1("t6_ready0", core_trans_ready_o, 1'b1);
    chk1("t6_no_err0", core_resp_valid_o, 1'b0);
    nxt();
    set(1'b1, 32'h0000_7104, 1'b0, 1'b0, 32'h0); #3;
    chk1("t6_ready1", core_trans_ready_o, 1'b1);
    chk1("t6_no_err1", core_resp_valid_o, 1'b0);
    nxt();
    set(1'b1, 32'h0000_7108, 1'b0, 1'b0, 32'h0); #3;
    chk1("t6_full", core_trans_ready_o, 1'b0);
    nxt();
    set(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00D1); nxt();
    set(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00D2); nxt();
    set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); nxt();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
